// File: rtl/fir_xifu_pkg.sv
// Shared types and constants for the FIR XIFU pipeline.
// Consumers: fir_xifu_ex, fir_xifu_dotp (FIR_XIFU_DOTP_SAT_EN honoured in dotp).
package fir_xifu_pkg;

    localparam int FIR_XIFU_LANE_WIDTH = 16;
    localparam logic [3:0] FIR_XIFU_BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        INSTR_INVALID  = 2'd0,
        INSTR_XFIRLW   = 2'd1,
        INSTR_XFIRSW   = 2'd2,
        INSTR_XFIRDOTP = 2'd3
    } fir_xifu_instr_t;

    typedef enum logic [1:0] {
        EX_EMPTY   = 2'd0,
        EX_MEM_REQ = 2'd1,
        EX_FULL    = 2'd2
    } fir_xifu_ex_state_t;

    typedef struct packed {
        fir_xifu_instr_t instr;
        logic [31:0]     base;
        logic [11:0]     offset;
        logic [4:0]      rs1;
        logic [4:0]      rd;
    } fir_xifu_id2ex_t;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] op_c;
    } fir_xifu_ctrl2ex_t;

    typedef struct packed {
        fir_xifu_instr_t instr;
        logic [31:0]     result;
        logic [4:0]      rs1;
        logic [4:0]      rd;
    } fir_xifu_ex2wb_t;

    // State entered when an instruction is accepted into EX.
    function automatic fir_xifu_ex_state_t issue_state(
        input fir_xifu_instr_t instr
    );
        unique case (instr)
            INSTR_XFIRDOTP: return EX_FULL;
            INSTR_XFIRLW,
            INSTR_XFIRSW:   return EX_MEM_REQ;
            default:        return EX_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/fir_xifu_dotp.sv
// 2x16b signed SIMD dot product with accumulate and optional Q shift.
// FIR_XIFU_DOTP_SAT_EN: clamp to 32b signed range instead of wrapping.
module fir_xifu_dotp
    import fir_xifu_pkg::*;
#(
    parameter int DOTP_SHIFT = 0
) (
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] op_c,
    output logic [31:0] result
);

    localparam int L = FIR_XIFU_LANE_WIDTH;

    logic signed [L-1:0] a_lo, a_hi, b_lo, b_hi;
    logic signed [31:0]  p_lo, p_hi, acc;
    logic signed [32:0]  p, p_sh;
    logic signed [33:0]  s;

    assign a_lo = op_a[L-1:0];
    assign a_hi = op_a[2*L-1:L];
    assign b_lo = op_b[L-1:0];
    assign b_hi = op_b[2*L-1:L];
    assign acc  = op_c;

    assign p_lo = 32'(a_lo) * 32'(b_lo);
    assign p_hi = 32'(a_hi) * 32'(b_hi);
    assign p    = 33'(p_lo) + 33'(p_hi);
    assign p_sh = p >>> DOTP_SHIFT;
    assign s    = 34'(acc) + 34'(p_sh);

`ifdef FIR_XIFU_DOTP_SAT_EN
    localparam logic signed [33:0] SMAX = 34'sh0_7FFF_FFFF;
    localparam logic signed [33:0] SMIN = 34'sh3_8000_0000;

    always_comb begin
        result = s[31:0];
        if (s > SMAX) begin
            result = 32'h7FFF_FFFF;
        end else if (s < SMIN) begin
            result = 32'h8000_0000;
        end
    end
`else
    logic unused_s_top;

    assign unused_s_top = ^s[33:32];
    assign result = s[31:0];
`endif

endmodule

// File: rtl/fir_xifu_ex.sv
// FIR XIFU execute stage: dot product, word memory request, hand-off to WB.
// FIR_XIFU_DOTP_SAT_EN selects saturating dot product (see fir_xifu_dotp).
module fir_xifu_ex
    import fir_xifu_pkg::*;
#(
    parameter int DOTP_SHIFT = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  fir_xifu_id2ex_t   id2ex_i,
    input  logic              id_valid_i,
    output logic              ex_ready_o,
    input  fir_xifu_ctrl2ex_t ctrl2ex_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    output fir_xifu_ex2wb_t   ex2wb_o,
    output logic              ex_valid_o,
    input  logic              wb_ready_i
);

    fir_xifu_ex_state_t state, next;
    fir_xifu_ex2wb_t    ex2wb_q;
    logic [31:0]        wdata_q;
    logic               kill_q;
    logic               ready;
    logic               accept;
    logic [31:0]        ea;
    logic [31:0]        dotp;

    fir_xifu_dotp #(
        .DOTP_SHIFT(DOTP_SHIFT)
    ) u_dotp (
        .op_a  (ctrl2ex_i.op_a),
        .op_b  (ctrl2ex_i.op_b),
        .op_c  (ctrl2ex_i.op_c),
        .result(dotp)
    );

    assign ea = id2ex_i.base + {{20{id2ex_i.offset[11]}}, id2ex_i.offset};

    always_comb begin
        ready  = 1'b0;
        accept = 1'b0;
        next   = state;
        unique case (state)
            EX_EMPTY: begin
                ready  = !flush_i;
                accept = id_valid_i && ready;
                if (accept) begin
                    next = issue_state(id2ex_i.instr);
                end
            end
            EX_MEM_REQ: begin
                if (mem_gnt_i) begin
                    next = (kill_q || flush_i) ? EX_EMPTY : EX_FULL;
                end
            end
            EX_FULL: begin
                ready  = wb_ready_i && !flush_i;
                accept = id_valid_i && ready;
                if (flush_i) begin
                    next = EX_EMPTY;
                end else if (wb_ready_i) begin
                    next = accept ? issue_state(id2ex_i.instr) : EX_EMPTY;
                end
            end
            default: next = EX_EMPTY;
        endcase
    end

    // Memory ops carry their unaligned ea as result from accept onward.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= EX_EMPTY;
            ex2wb_q <= '0;
            wdata_q <= '0;
            kill_q  <= 1'b0;
        end else begin
            state <= next;
            if (accept && id2ex_i.instr != INSTR_INVALID) begin
                ex2wb_q.instr  <= id2ex_i.instr;
                ex2wb_q.result <= (id2ex_i.instr == INSTR_XFIRDOTP) ?
                                  dotp : ea;
                ex2wb_q.rs1    <= id2ex_i.rs1;
                ex2wb_q.rd     <= id2ex_i.rd;
                wdata_q        <= ctrl2ex_i.op_b;
            end
            if (state == EX_MEM_REQ) begin
                kill_q <= (kill_q || flush_i) && !mem_gnt_i;
            end else begin
                kill_q <= 1'b0;
            end
        end
    end

    assign ex_ready_o  = ready;
    assign ex_valid_o  = (state == EX_FULL);
    assign mem_req_o   = (state == EX_MEM_REQ);
    assign mem_we_o    = mem_req_o && (ex2wb_q.instr == INSTR_XFIRSW);
    assign mem_addr_o  = mem_req_o ? {ex2wb_q.result[31:2], 2'b00} : '0;
    assign mem_wdata_o = mem_we_o ? wdata_q : '0;
    assign mem_be_o    = FIR_XIFU_BE_WORD;
    assign ex2wb_o     = ex2wb_q;

endmodule

// File: tb/tb_fir_xifu_ex.sv
// Self-checking bench for fir_xifu_ex: scoreboard model plus directed vectors.
module tb_fir_xifu_ex;
    import fir_xifu_pkg::*;

    localparam int SHIFT = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              flush = 1'b0;
    fir_xifu_id2ex_t   id2ex = '0;
    logic              id_valid = 1'b0;
    logic              ex_ready;
    fir_xifu_ctrl2ex_t ctrl = '0;
    logic              mem_req;
    logic              gnt = 1'b0;
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    fir_xifu_ex2wb_t   ex2wb;
    logic              ex_valid;
    logic              wb_ready = 1'b1;

    fir_xifu_ex_state_t unused_state;

    fir_xifu_ex2wb_t ex_q[$];
    mem_exp_t        mem_q[$];
    int checks = 0;
    int errors = 0;
    int gnt_delay = 0;
    int wc = 0;
    int req_cyc = 0;
    int last_req = 0;

    fir_xifu_ex #(
        .DOTP_SHIFT(SHIFT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .id2ex_i    (id2ex),
        .id_valid_i (id_valid),
        .ex_ready_o (ex_ready),
        .ctrl2ex_i  (ctrl),
        .mem_req_o  (mem_req),
        .mem_gnt_i  (gnt),
        .mem_we_o   (we),
        .mem_addr_o (addr),
        .mem_wdata_o(wdata),
        .mem_be_o   (be),
        .ex2wb_o    (ex2wb),
        .ex_valid_o (ex_valid),
        .wb_ready_i (wb_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference dot product from plain integer arithmetic.
    function automatic logic [31:0] m_dotp(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] c);
        longint lo, hi, p, s;
        lo = longint'($signed(a[15:0])) * longint'($signed(b[15:0]));
        hi = longint'($signed(a[31:16])) * longint'($signed(b[31:16]));
        p  = (lo + hi) >>> SHIFT;
        s  = longint'($signed(c)) + p;
`ifdef FIR_XIFU_DOTP_SAT_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] m_ea(input logic [31:0] base,
                                         input logic [11:0] off);
        return base + {{20{off[11]}}, off};
    endfunction

    // Memory slave: grant after gnt_delay waiting cycles.
    initial forever begin
        @(posedge clk);
        #2;
        if (rst_n && mem_req) begin
            gnt = (wc >= gnt_delay);
            wc  = gnt ? 0 : wc + 1;
        end else begin
            gnt = 1'b0;
            wc  = 0;
        end
    end

    // Compare process: DUT outputs against the scoreboard every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("be", 64'(be), 64'hF);
            if (mem_req) begin
                req_cyc++;
                if (mem_q.size() == 0) begin
                    fail("spurious_mem_req");
                end else begin
                    chk("mem_addr", 64'(addr), 64'(mem_q[0].addr));
                    chk("mem_we", 64'(we), 64'(mem_q[0].we));
                    if (mem_q[0].we)
                        chk("mem_wdata", 64'(wdata), 64'(mem_q[0].wdata));
                    if (gnt) begin
                        void'(mem_q.pop_front());
                        last_req = req_cyc;
                        req_cyc  = 0;
                    end
                end
            end
            if (ex_valid) begin
                if (ex_q.size() == 0) begin
                    fail("spurious_ex_valid");
                end else begin
                    chk("ex2wb", 64'(ex2wb), 64'(ex_q[0]));
                    if (flush || wb_ready) void'(ex_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input fir_xifu_instr_t ins,
                         input logic [31:0] base, input logic [11:0] off,
                         input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c,
                         input bit killed);
        bit ok;
        fir_xifu_ex2wb_t e;
        mem_exp_t m;
        ok = 0;
        id2ex.instr  = ins;
        id2ex.base   = base;
        id2ex.offset = off;
        id2ex.rs1    = rd + 5'd1;
        id2ex.rd     = rd;
        ctrl.op_a    = a;
        ctrl.op_b    = b;
        ctrl.op_c    = c;
        id_valid     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ex_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            e.instr  = ins;
            e.result = (ins == INSTR_XFIRDOTP) ?
                       m_dotp(a, b, c) : m_ea(base, off);
            e.rs1    = rd + 5'd1;
            e.rd     = rd;
            if (ins != INSTR_INVALID && !killed) ex_q.push_back(e);
            if (ins == INSTR_XFIRLW || ins == INSTR_XFIRSW) begin
                m.addr  = {e.result[31:2], 2'b00};
                m.we    = (ins == INSTR_XFIRSW);
                m.wdata = b;
                mem_q.push_back(m);
            end
        end else begin
            fail("issue_timeout");
        end
        @(posedge clk);
        #1;
        id_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ex_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("valid_timeout");
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 64'(ex_valid), 64'h0);
        chk("rst_req", 64'(mem_req), 64'h0);
        chk("rst_we", 64'(we), 64'h0);
        chk("rst_addr", 64'(addr), 64'h0);
        chk("rst_wdata", 64'(wdata), 64'h0);
        chk("rst_ex2wb", 64'(ex2wb), 64'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 1: DOTP, valid one cycle after accept
        issue(INSTR_XFIRDOTP, 0, 0, 5'd7,
              32'h0002_0003, 32'h0004_0005, 32'd10, 0);
        chk("t1_valid", 64'(ex_valid), 64'h1);
        chk("t1_result", 64'(ex2wb.result), 64'd33);
        chk("t1_rd", 64'(ex2wb.rd), 64'd7);
        step();

        // 2: LW with three wait cycles
        gnt_delay = 3;
        issue(INSTR_XFIRLW, 32'h1000, 12'hFFC, 5'd3, 0, 0, 0, 0);
        chk("t2_req", 64'(mem_req), 64'h1);
        chk("t2_addr", 64'(addr), 64'h0FFC);
        chk("t2_we", 64'(we), 64'h0);
        wait_valid();
        chk("t2_req_cycles", 64'(last_req), 64'd4);
        chk("t2_result", 64'(ex2wb.result), 64'h0FFC);
        step();

        // 3: SW to unaligned base
        gnt_delay = 0;
        issue(INSTR_XFIRSW, 32'h2003, 12'h000, 5'd4,
              0, 32'hDEAD_BEEF, 0, 0);
        chk("t3_addr", 64'(addr), 64'h2000);
        chk("t3_we", 64'(we), 64'h1);
        chk("t3_wdata", 64'(wdata), 64'hDEAD_BEEF);
        chk("t3_be", 64'(be), 64'hF);
        wait_valid();
        chk("t3_result", 64'(ex2wb.result), 64'h2003);
        step();

        // 4: back-pressure then back-to-back DOTP
        wb_ready = 1'b0;
        issue(INSTR_XFIRDOTP, 0, 0, 5'd9,
              32'h0001_0002, 32'h0003_0004, 32'd5, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_ready", 64'(ex_ready), 64'h0);
            chk("t4_valid", 64'(ex_valid), 64'h1);
        end
        chk("t4_result", 64'(ex2wb.result), 64'd16);
        step();
        wb_ready = 1'b1;
        issue(INSTR_XFIRDOTP, 0, 0, 5'd10,
              32'hFFFF_0001, 32'h0002_0003, 32'd100, 0);
        chk("t4_nobubble", 64'(ex_valid), 64'h1);
        chk("t4_result2", 64'(ex2wb.result), 64'h65);
        step();

        // 5: overflow corner
        issue(INSTR_XFIRDOTP, 0, 0, 5'd11,
              32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 0);
`ifdef FIR_XIFU_DOTP_SAT_EN
        chk("t5_sat", 64'(ex2wb.result), 64'h7FFF_FFFF);
`else
        chk("t5_wrap", 64'(ex2wb.result), 64'hFFFF_FFFF);
`endif
        step();

        // 6a: flush in FULL
        wb_ready = 1'b0;
        issue(INSTR_XFIRDOTP, 0, 0, 5'd12, 32'd1, 32'd1, 0, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_flush_full", 64'(ex_valid), 64'h0);
        wb_ready = 1'b1;
        step();

        // 6b: flush in MEM_REQ
        gnt_delay = 3;
        issue(INSTR_XFIRLW, 32'h3000, 12'h010, 5'd13, 0, 0, 0, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ex_valid) seen++;
        end
        chk("t6_kill_valid", 64'(seen), 64'h0);
        chk("t6_kill_granted", 64'(mem_q.size()), 64'h0);
        step();

        // 6c: INSTR_INVALID dropped
        issue(INSTR_INVALID, 0, 0, 5'd14, 0, 0, 0, 0);
        chk("t6_inv_valid", 64'(ex_valid), 64'h0);
        chk("t6_inv_req", 64'(mem_req), 64'h0);
        step();

        // 6d: async reset during MEM_REQ
        gnt_delay = 100;
        issue(INSTR_XFIRLW, 32'h4000, 12'h000, 5'd15, 0, 0, 0, 1);
        chk("t6_pre_rst_req", 64'(mem_req), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 64'(mem_req), 64'h0);
        chk("t6_rst_valid", 64'(ex_valid), 64'h0);
        mem_q.delete();
        ex_q.delete();
        req_cyc = 0;
        step();
        rst_n = 1'b1;
        gnt_delay = 0;
        step();
        issue(INSTR_XFIRDOTP, 0, 0, 5'd2,
              32'hFFFE_0004, 32'h0003_FFFF, 32'd1, 0);
        chk("t6_recover", 64'(ex2wb.result), 64'hFFFF_FFF7);

        for (int i = 0; i < 5; i++) step();
        chk("ex_q_empty", 64'(ex_q.size()), 64'h0);
        chk("mem_q_empty", 64'(mem_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        fail("global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    assign unused_state = EX_EMPTY;

endmodule
